// File: rtl/idc_sequencer.sv
// ---------------------------------------------------------------------------
// idc_sequencer
//
// Purpose:
//   Accepts a 16-bit command word through a valid/ready handshake. It then
//   issues a train of step pulses on IDC_control to an IDC register bank.
//   Word layout: [15:12] opcode, [11:8] register select, [7:0] repeat count.
//   Opcodes 1/2/3 map to increment (01), decrement (10) and clear (11).
//   Only register selects 9..12 are legal. An illegal word is accepted and
//   then rejected with a one-cycle error pulse. It never reaches the bank.
//
// Parameters:
//   GAP_CYCLES      idle (00) cycles inserted between successive step
//                   pulses of one instruction, 0..3
//
// Ports:
//   clock           single clock, all state changes on its rising edge
//   reset_n         synchronous active-low reset
//   instr_valid     upstream offers instruction_in this cycle
//   instr_ready     block can accept a word this cycle (IDLE only)
//   instruction_in  offered command word
//   IDC_control     registered bank command: 00 hold, 01 inc, 10 dec, 11 clr
//   instruction     registered copy of the accepted word, for bank decode
//   busy            high whenever the sequencer is not IDLE
//   done            one-cycle pulse when a legal instruction completes
//   error           one-cycle pulse when an illegal instruction is rejected
// ---------------------------------------------------------------------------
module idc_sequencer #(
  parameter int GAP_CYCLES = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instruction_in,
  output logic [1:0]  IDC_control,
  output logic [15:0] instruction,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } state_t;

  // The gap counter counts down to zero, so its load value is one less
  // than the gap length. With no gap the GAP state is never entered.
  localparam int         GAP_LOAD_INT = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;
  localparam logic [1:0] GAP_LOAD     = GAP_LOAD_INT[1:0];

  state_t      state_q;
  logic [1:0]  code_q;
  logic [7:0]  remaining_q;
  logic [1:0]  gap_cnt_q;
  logic [1:0]  idc_q;
  logic [15:0] instr_q;
  logic        ready_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;

  // Decode of the offered word. It is only used on the accepting edge.
  logic [1:0]  dec_code;
  logic        dec_reg_ok;
  logic        dec_legal;
  logic [7:0]  dec_count;

  always_comb begin
    dec_code   = 2'b00;
    dec_reg_ok = 1'b0;
    dec_count  = 8'd1;

    case (instruction_in[15:12])
      4'h1:    dec_code = 2'b01;
      4'h2:    dec_code = 2'b10;
      4'h3:    dec_code = 2'b11;
      default: dec_code = 2'b00;
    endcase

    case (instruction_in[11:8])
      4'h9, 4'hA, 4'hB, 4'hC: dec_reg_ok = 1'b1;
      default:                dec_reg_ok = 1'b0;
    endcase

    // A zero code marks an illegal opcode.
    dec_legal = (dec_code != 2'b00) && dec_reg_ok;

    // Clear always issues exactly one step. A zero repeat count means one
    // step, so the remaining counter never starts at zero.
    if (dec_code == 2'b11) begin
      dec_count = 8'd1;
    end else if (instruction_in[7:0] == 8'd0) begin
      dec_count = 8'd1;
    end else begin
      dec_count = instruction_in[7:0];
    end
  end

  // Sequencer FSM. Every output is a register, so IDC_control changes
  // exactly on the clock edge after the decision that selects it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      code_q      <= 2'b00;
      remaining_q <= 8'd0;
      gap_cnt_q   <= 2'd0;
      idc_q       <= 2'b00;
      instr_q     <= 16'h0000;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      // done and error are single-cycle pulses.
      done_q  <= 1'b0;
      error_q <= 1'b0;

      case (state_q)
        IDLE: begin
          idc_q <= 2'b00;
          if (instr_valid && ready_q) begin
            instr_q <= instruction_in;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (dec_legal) begin
              state_q     <= ISSUE;
              code_q      <= dec_code;
              remaining_q <= dec_count;
              idc_q       <= dec_code;
            end else begin
              // Rejected words skip straight to FINISH. They never touch
              // the bank.
              state_q <= FINISH;
              code_q  <= 2'b00;
              error_q <= 1'b1;
            end
          end
        end

        ISSUE: begin
          if (remaining_q > 8'd1) begin
            remaining_q <= remaining_q - 8'd1;
            if (GAP_CYCLES > 0) begin
              state_q   <= GAP;
              gap_cnt_q <= GAP_LOAD;
              idc_q     <= 2'b00;
            end else begin
              // Back-to-back steps: hold the code for another cycle.
              idc_q <= code_q;
            end
          end else begin
            // The last step was this cycle. The counter stays at 1 and
            // does not wrap.
            state_q <= FINISH;
            idc_q   <= 2'b00;
            done_q  <= 1'b1;
          end
        end

        GAP: begin
          idc_q <= 2'b00;
          if (gap_cnt_q == 2'd0) begin
            state_q <= ISSUE;
            idc_q   <= code_q;
          end else begin
            gap_cnt_q <= gap_cnt_q - 2'd1;
          end
        end

        FINISH: begin
          state_q <= IDLE;
          idc_q   <= 2'b00;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          idc_q   <= 2'b00;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign IDC_control = idc_q;
  assign instruction = instr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_idc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_idc_sequencer
//
// The bench drives two sequencers: dut0 with GAP_CYCLES=0 and dut1 with
// GAP_CYCLES=1. A timeline model predicts every output of each sequencer
// from the accept cycle. It uses the step count, gap length and legality
// of the word. A compare process checks both sequencers on every falling
// edge. The directed tests also check hand-computed traces.
// ---------------------------------------------------------------------------
module tb_idc_sequencer;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       valid_v;
  logic [1:0][15:0] win_v;
  logic [1:0]       ready_v;
  logic [1:0][1:0]  idc_v;
  logic [1:0][15:0] instr_v;
  logic [1:0]       busy_v;
  logic [1:0]       done_v;
  logic [1:0]       err_v;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  idc_sequencer #(.GAP_CYCLES(0)) u_dut0 (
    .clock          (clk),
    .reset_n        (reset_n),
    .instr_valid    (valid_v[0]),
    .instr_ready    (ready_v[0]),
    .instruction_in (win_v[0]),
    .IDC_control    (idc_v[0]),
    .instruction    (instr_v[0]),
    .busy           (busy_v[0]),
    .done           (done_v[0]),
    .error          (err_v[0])
  );

  idc_sequencer #(.GAP_CYCLES(1)) u_dut1 (
    .clock          (clk),
    .reset_n        (reset_n),
    .instr_valid    (valid_v[1]),
    .instr_ready    (ready_v[1]),
    .instruction_in (win_v[1]),
    .IDC_control    (idc_v[1]),
    .instruction    (instr_v[1]),
    .busy           (busy_v[1]),
    .done           (done_v[1]),
    .error          (err_v[1])
  );

  task automatic chk(input string nm, input int i, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t got=%h expected=%h", nm, i, $time, got, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  int          cyc = 0;
  logic        started = 1'b0;
  logic        act   [2] = '{1'b0, 1'b0};
  logic        leg   [2];
  logic [1:0]  mcode [2];
  int          nst   [2];
  int          acc_c [2];
  logic [15:0] minstr[2] = '{16'h0, 16'h0};

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 1;
  endfunction

  // Expected outputs during cycle c: {busy, ready, error, done, idc[1:0]}.
  // A legal word has L = N + (N-1)*gap busy cycles of step/gap activity.
  // A step falls on every (gap+1)-th cycle. The done cycle follows, and
  // ready returns after that. An illegal word has one error cycle.
  function automatic logic [5:0] exp_at(input int i, input int c);
    int d, g, len;
    if (!act[i]) return 6'b010000;
    d = c - acc_c[i];
    g = gap_of(i);
    if (!leg[i]) begin
      if (d == 1) return 6'b101000;
      return 6'b010000;
    end
    len = nst[i] + (nst[i] - 1) * g;
    if (d >= 1 && d <= len) begin
      if (((d - 1) % (g + 1)) == 0) return {4'b1000, mcode[i]};
      return 6'b100000;
    end
    if (d == len + 1) return 6'b100100;
    return 6'b010000;
  endfunction

  always @(posedge clk) begin
    logic [5:0] e;
    logic [3:0] op;
    logic [3:0] rs;
    logic [7:0] ct;
    if (!reset_n) started <= 1'b1;
    for (int i = 0; i < 2; i++) begin
      e  = exp_at(i, cyc);
      op = win_v[i][15:12];
      rs = win_v[i][11:8];
      ct = win_v[i][7:0];
      if (!reset_n) begin
        act[i]    <= 1'b0;
        minstr[i] <= 16'h0000;
      end else if (e[4] && valid_v[i]) begin
        act[i]    <= 1'b1;
        acc_c[i]  <= cyc;
        minstr[i] <= win_v[i];
        leg[i]    <= (op >= 4'd1 && op <= 4'd3) && (rs >= 4'd9 && rs <= 4'd12);
        mcode[i]  <= op[1:0];
        nst[i]    <= (op == 4'd3) ? 1 : ((ct == 8'd0) ? 1 : int'(ct));
      end
    end
    cyc <= cyc + 1;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [5:0] e;
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        e = exp_at(i, cyc);
        chk("idc_control", i, {14'd0, idc_v[i]}, {14'd0, e[1:0]});
        chk("done",        i, {15'd0, done_v[i]},  {15'd0, e[2]});
        chk("error",       i, {15'd0, err_v[i]},   {15'd0, e[3]});
        chk("instr_ready", i, {15'd0, ready_v[i]}, {15'd0, e[4]});
        chk("busy",        i, {15'd0, busy_v[i]},  {15'd0, e[5]});
        chk("instruction", i, instr_v[i], minstr[i]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [4:0] cap [8];   // {ready, error, done, idc}
  int cap_steps, cap_done_idx, cap_done_cnt, cap_err_cnt;

  task automatic send(input int i, input logic [15:0] w, input int ncap);
    int waited;
    logic rdy;
    logic [4:0] t;
    waited = 0;
    @(posedge clk);
    #1;
    win_v[i]   = w;
    valid_v[i] = 1'b1;
    forever begin
      rdy = ready_v[i];
      @(posedge clk);
      if (rdy) break;
      #1;
      waited++;
      if (waited > 50) begin
        n_vec++;
        n_err++;
        $display("FAIL accept_timeout dut%0d word=%h got=no_accept expected=accept", i, w);
        break;
      end
    end
    #1;
    valid_v[i] = 1'b0;
    cap_steps = 0; cap_done_idx = -1; cap_done_cnt = 0; cap_err_cnt = 0;
    for (int k = 0; k < 8; k++) cap[k] = 5'h1F;
    for (int k = 0; k < ncap; k++) begin
      @(negedge clk);
      t = {ready_v[i], err_v[i], done_v[i], idc_v[i]};
      if (k < 8) cap[k] = t;
      if (idc_v[i] != 2'b00) cap_steps++;
      if (done_v[i]) begin
        if (cap_done_idx < 0) cap_done_idx = k;
        cap_done_cnt++;
      end
      if (err_v[i]) cap_err_cnt++;
    end
  endtask

  initial begin
    int pulses, guard, dcount;
    // An instruction offered during reset must not be accepted.
    reset_n  = 1'b0;
    valid_v  = 2'b01;
    win_v[0] = 16'h1903;
    win_v[1] = 16'h0000;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    valid_v = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_idc",   i, {14'd0, idc_v[i]}, 16'h0);
      chk("rst_instr", i, instr_v[i], 16'h0000);
      chk("rst_busy",  i, {15'd0, busy_v[i]}, 16'h0);
      chk("rst_ready", i, {15'd0, ready_v[i]}, 16'h1);
    end

    // INC x3, no gap.
    send(0, 16'h1903, 8);
    chk("inc3_c0", 0, {11'd0, cap[0]}, 16'h01);
    chk("inc3_c1", 0, {11'd0, cap[1]}, 16'h01);
    chk("inc3_c2", 0, {11'd0, cap[2]}, 16'h01);
    chk("inc3_done", 0, {11'd0, cap[3]}, 16'h04);
    chk("inc3_ready", 0, {11'd0, cap[4]}, 16'h10);
    chk("inc3_instr", 0, instr_v[0], 16'h1903);

    // CLR ignores count; DEC with count 0 is one step.
    send(0, 16'h3C05, 6);
    chk("clr_c0", 0, {11'd0, cap[0]}, 16'h03);
    chk("clr_c1", 0, {11'd0, cap[1]}, 16'h04);
    chk("clr_steps", 0, cap_steps[15:0], 16'd1);
    send(0, 16'h2A00, 6);
    chk("dec0_c0", 0, {11'd0, cap[0]}, 16'h02);
    chk("dec0_steps", 0, cap_steps[15:0], 16'd1);

    // Illegal register select and illegal opcode.
    send(0, 16'h1503, 6);
    chk("badreg_err", 0, cap_err_cnt[15:0], 16'd1);
    chk("badreg_done", 0, cap_done_cnt[15:0], 16'd0);
    chk("badreg_steps", 0, cap_steps[15:0], 16'd0);
    send(0, 16'h7903, 6);
    chk("badop_err", 0, cap_err_cnt[15:0], 16'd1);
    chk("badop_done", 0, cap_done_cnt[15:0], 16'd0);
    chk("badop_steps", 0, cap_steps[15:0], 16'd0);

    // Maximum repeat count.
    send(0, 16'h2CFF, 262);
    chk("dec255_steps", 0, cap_steps[15:0], 16'd255);
    chk("dec255_done_at", 0, cap_done_idx[15:0], 16'd255);

    // One-cycle gap between steps.
    send(1, 16'h1B02, 6);
    chk("gap_c0", 1, {11'd0, cap[0]}, 16'h01);
    chk("gap_c1", 1, {11'd0, cap[1]}, 16'h00);
    chk("gap_c2", 1, {11'd0, cap[2]}, 16'h01);
    chk("gap_done", 1, {11'd0, cap[3]}, 16'h04);

    // Reset aborts an operation after its fourth step.
    send(1, 16'h1B10, 0);
    pulses = 0;
    guard  = 0;
    while (pulses < 4 && guard < 100) begin
      @(negedge clk);
      if (idc_v[1] != 2'b00) pulses++;
      guard++;
    end
    chk("abort_pulses_seen", 1, pulses[15:0], 16'd4);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_idc", 1, {14'd0, idc_v[1]}, 16'h0);
    chk("abort_busy", 1, {15'd0, busy_v[1]}, 16'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", 1, {15'd0, ready_v[1]}, 16'h1);
    chk("abort_instr", 1, instr_v[1], 16'h0000);
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_v[1] || idc_v[1] != 2'b00) dcount++;
    end
    chk("abort_no_more", 1, dcount[15:0], 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/idc_sequencer.md
IDC_SEQUENCER -- requirements
Module: idc_sequencer

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 0, meaning the number of idle cycles (IDC_control=00) between successive step pulses of one instruction; legal range 0..3.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on posedge clock.
REQ-003 The block SHALL have port reset_n, input, 1, synchronous active-low reset sampled on posedge clock.
REQ-004 The block SHALL have port instr_valid, input, 1, upstream offers instruction_in this cycle.
REQ-005 The block SHALL have port instr_ready, output, 1, block can accept an instruction this cycle.
REQ-006 The block SHALL have port instruction_in, input, 16, offered command word: [15:12] opcode, [11:8] register select, [7:0] repeat count.
REQ-007 The block SHALL have port IDC_control, output, 2, registered command to the IDC register bank: 00 hold, 01 increment, 10 decrement, 11 clear.
REQ-008 The block SHALL have port instruction, output, 16, registered copy of the accepted word, stable for the whole operation, for the bank's [11:8] decode.
REQ-009 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-010 The block SHALL have port done, output, 1, one-cycle pulse at completion of a legal instruction.
REQ-011 The block SHALL have port error, output, 1, one-cycle pulse on rejection of an illegal instruction.

Function
REQ-012 The block SHALL implement states IDLE, ISSUE, GAP, FINISH; instr_ready SHALL be 1 only in IDLE.
REQ-013 The block SHALL accept an instruction on a posedge where instr_valid=1 and instr_ready=1, latching instruction_in into instruction on that edge.
REQ-014 The block SHALL decode opcode 0001 as INC (01), 0010 as DEC (10), 0011 as CLR (11); all other opcodes SHALL be illegal.
REQ-015 The block SHALL treat register select values 1001, 1010, 1011, 1100 as legal; any other value SHALL make the instruction illegal.
REQ-016 For INC/DEC the step count SHALL be instruction_in[7:0], with 0 treated as 1 (range 1..255); CLR SHALL always issue exactly one step, ignoring [7:0].
REQ-017 On accepting a legal instruction the block SHALL enter ISSUE and drive the decoded code on IDC_control starting the following cycle.
REQ-018 In ISSUE the block SHALL hold IDC_control for exactly one cycle per step and decrement an 8-bit remaining counter; with remaining>1 it SHALL go to GAP (if GAP_CYCLES>0, IDC_control=00 for GAP_CYCLES cycles) or stay in ISSUE (if GAP_CYCLES=0); with remaining=1 it SHALL go to FINISH.
REQ-019 In FINISH the block SHALL drive IDC_control=00, pulse done=1 for one cycle, and return to IDLE on the next edge.
REQ-020 For an accepted illegal instruction the block SHALL never drive a nonzero IDC_control, SHALL pulse error=1 for one cycle in FINISH, and done SHALL stay 0.
REQ-021 Latency: accept at edge k gives IDC_control nonzero in the N step cycles starting at k+1 (contiguous when GAP_CYCLES=0), done high at cycle k+N+1+(N-1)*GAP_CYCLES, and instr_ready high again one cycle later.
REQ-022 IDC_control SHALL be 00 in IDLE, GAP and FINISH; done and error SHALL never be high together.
REQ-023 instr_valid while instr_ready=0 SHALL be ignored without side effect; upstream holds the word.
REQ-024 The remaining counter SHALL never wrap: no decrement below 1, and no issue with a zero count.

Reset
REQ-025 With reset_n=0 at a posedge the block SHALL set state=IDLE, IDC_control=00, instruction=16'h0000, remaining=0, done=0, error=0, busy=0, with instr_ready=1 from the first cycle after release.
REQ-026 Reset SHALL override any in-progress operation; no further step pulse, done or error SHALL follow, and the aborted instruction SHALL be discarded.
REQ-027 An instr_valid presented in the same cycle as reset_n=0 SHALL NOT be accepted.

Verification
REQ-028 Reset: reset_n=0 for 2 cycles, then 1 -> IDC_control=00, instruction=0000, busy=0, instr_ready=1.
REQ-029 GAP_CYCLES=0, accept 16'h1903 -> IDC_control=01 for 3 consecutive cycles, instruction=16'h1903 throughout, done pulse in the next cycle, then instr_ready=1.
REQ-030 Accept 16'h3C05 -> IDC_control=11 for exactly 1 cycle (count ignored), then done; accept 16'h2A00 -> IDC_control=10 for exactly 1 cycle.
REQ-031 Accept 16'h1503 (bad register) and 16'h7903 (bad opcode) -> IDC_control stays 00, error pulses once each, done stays 0.
REQ-032 GAP_CYCLES=1, accept 16'h1B02 -> IDC_control sequence 01,00,01, then done.
REQ-033 Accept 16'h1B10, assert reset_n=0 after the 4th pulse -> IDC_control=00 from the next edge, no done, busy=0, instr_ready=1 after release.
